mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath (PC, unified memory, IR, MDR, register bank, A/B, ALU/ALUOut, EPC).
//  Decodes the IR opcode/funct and sequences the per-cycle datapath controls for fetch, decode, execute, memory and writeback.
//  Handles memory wait states, overflow and illegal-opcode exceptions, and exports the current state code for debug.
// PARAMETERS
//  MEM_WAIT  1  extra cycles between issuing a memory read and MemData being valid (0..15)
// PORTS
//  Clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  Opcode       in   6  IR[31:26]
//  Funct        in   6  IR[5:0]
//  Zero         in   1  ALU zero flag (combinational, current cycle)
//  Overflow     in   1  ALU signed-overflow flag (combinational, current cycle)
//  PCWrite, PCWriteCond, BranchNE, IorD, wr, MemtoReg, IRWrite, RegWrite, RegDst, RegReset  out 1 each  datapath strobes/selects
//  ALUSrcA      out  1  0=PC, 1=A
//  ALUSrcB      out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=use funct, 11=reserved (never driven)
//  PCSource     out  2  00=ALU, 01=ALUOut, 10=jump addr, 11=exception vector
//  A_load, B_load, ALUOut_load, MDR_load, EPCWrite  out 1 each  register load enables
//  Estado       out  8  current state code
// BEHAVIOUR
//  Moore FSM: all outputs are decoded from the state register (plus wait counter); unlisted outputs are 0 in each state.
//  reset asserted (any cycle, mid-instruction included): state<=RESET, wait counter<=0, ovf flag<=0 immediately; all outputs 0 except RegReset=1.
//  State codes (Estado): RESET=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 REXEC=7 RWB=8 BRANCH=9 JUMP=10 IEXEC=11 IWB=12 EXC=13.
//  RESET: RegReset=1 for one cycle after reset deasserts -> FETCH.
//  FETCH: IorD=0 wr=0 ALUSrcA=0 ALUSrcB=01 ALUOp=00. Held MEM_WAIT cycles (counter counts up, IRWrite/PCWrite=0);
//   on the final cycle IRWrite=1, PCWrite=1, PCSource=00, counter clears -> DECODE.
//  DECODE: A_load=B_load=1, ALUSrcA=0 ALUSrcB=11 ALUOp=00 ALUOut_load=1 (branch target). Next by Opcode:
//   0x00->REXEC, 0x23/0x2B->MEMADR, 0x04/0x05->BRANCH, 0x02->JUMP, 0x08->IEXEC, anything else->EXC.
//  MEMADR: ALUSrcA=1 ALUSrcB=10 ALUOp=00 ALUOut_load=1 -> MEMRD (0x23) or MEMWR (0x2B).
//  MEMRD: IorD=1 wr=0; held MEM_WAIT cycles; MDR_load=1 on final cycle only -> MEMWB.
//  MEMWB: RegDst=0 MemtoReg=1 RegWrite=1 -> FETCH.
//  MEMWR: IorD=1 wr=1 for exactly one cycle (no wait) -> FETCH.
//  REXEC / IEXEC: ALUSrcA=1, ALUSrcB=00 / 10, ALUOp=10 / 00, ALUOut_load=1; ovf flag<=Overflow if
//   (REXEC and Funct in {0x20,0x22}) or IEXEC, else 0 -> RWB / IWB.
//  RWB / IWB: if ovf flag=1: RegWrite=0 -> EXC; else RegWrite=1, MemtoReg=0, RegDst=1 (RWB) / 0 (IWB) -> FETCH.
//  BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01 BranchNE=(Opcode==0x05) -> FETCH.
//   Datapath takes branch when Zero^BranchNE; controller ignores Zero.
//  JUMP: PCWrite=1 PCSource=10 -> FETCH.
//  EXC: ALUSrcA=0 ALUSrcB=01 ALUOp=01 (PC-4) EPCWrite=1; PCWrite=1 PCSource=11; ovf flag<=0 -> FETCH.
//  Cycle counts incl. fetch, W=MEM_WAIT: lw 5+2W, sw 4+W, R/addi 4+W, beq/bne/j 3+W, illegal 3+W, overflow trap 5+W.
//  MEM_WAIT=0: FETCH and MEMRD last 1 cycle; counter unused. Counter width 4 bits, never wraps (clears on exit).
//  Estado and outputs change only on Clk rising edge, except the asynchronous entry into RESET.
// TESTING
//  reset mid-MEMRD (lw, W=1) -> next edge-independent Estado=0, RegWrite/wr/PCWrite=0; after release RESET 1 cycle then FETCH.
//  W=1, lw (0x23) -> Estado 1,1,2,3,4,4,5,1; MDR_load only in 2nd MEMRD cycle; RegWrite=1 MemtoReg=1 in MEMWB.
//  R-type add, Funct=0x20, Overflow=1 in REXEC -> RWB has RegWrite=0, then EXC: EPCWrite=1 PCSource=11, then FETCH.
//  R-type addu Funct=0x21, Overflow=1 -> no trap, RWB RegWrite=1 RegDst=1, then FETCH.
//  bne Opcode=0x05 -> BRANCH with PCWriteCond=1 BranchNE=1 PCSource=01 ALUOp=01; total 3+W cycles.
//  Opcode=0x3F -> DECODE->EXC->FETCH, no RegWrite/wr asserted at any point.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       Overflow;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       BranchNE;
   logic       IorD;
   logic       wr;
   logic       MemtoReg;
   logic       IRWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       RegReset;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic       A_load;
   logic       B_load;
   logic       ALUOut_load;
   logic       MDR_load;
   logic       EPCWrite;
   logic [7:0] Estado;

   modport master (
      input  Opcode, Funct, Zero, Overflow,
      output PCWrite, PCWriteCond, BranchNE, IorD, wr,
      output MemtoReg, IRWrite, RegWrite, RegDst, RegReset,
      output ALUSrcA, ALUSrcB, ALUOp, PCSource,
      output A_load, B_load, ALUOut_load, MDR_load, EPCWrite,
      output Estado
   );

   modport slave (
      output Opcode, Funct, Zero, Overflow,
      input  PCWrite, PCWriteCond, BranchNE, IorD, wr,
      input  MemtoReg, IRWrite, RegWrite, RegDst, RegReset,
      input  ALUSrcA, ALUSrcB, ALUOp, PCSource,
      input  A_load, B_load, ALUOut_load, MDR_load, EPCWrite,
      input  Estado
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath, with memory
// wait states and overflow / illegal-opcode traps.
module mips_multicycle_control #(
   parameter int MEM_WAIT = 1
) (
   input  logic Clk,
   input  logic reset,
   mips_multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REXEC  = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_IEXEC  = 4'd11,
      S_IWB    = 4'd12,
      S_EXC    = 4'd13
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       ovf, ovf_n;
   logic       done;
   logic       arith_trap;
   logic       unused_zero;

   // Branch resolution (Zero ^ BranchNE) happens in the datapath.
   assign unused_zero = bus.Zero;
   assign done        = (cnt == WAIT_LAST);
   assign arith_trap  = (bus.Funct == 6'h20) || (bus.Funct == 6'h22);
   assign bus.Estado  = {4'b0000, state};

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state <= S_RESET;
         cnt   <= 4'd0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ovf   <= ovf_n;
      end
   end

   always_comb begin
      state_n         = state;
      cnt_n           = cnt;
      ovf_n           = ovf;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.BranchNE    = 1'b0;
      bus.IorD        = 1'b0;
      bus.wr          = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegReset    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = 2'b00;
      bus.PCSource    = 2'b00;
      bus.A_load      = 1'b0;
      bus.B_load      = 1'b0;
      bus.ALUOut_load = 1'b0;
      bus.MDR_load    = 1'b0;
      bus.EPCWrite    = 1'b0;
      unique case (state)
         S_RESET: begin
            bus.RegReset = 1'b1;
            state_n      = S_FETCH;
         end
         S_FETCH: begin
            bus.ALUSrcB = 2'b01;
            if (done) begin
               bus.IRWrite = 1'b1;
               bus.PCWrite = 1'b1;
               cnt_n       = 4'd0;
               state_n     = S_DECODE;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         S_DECODE: begin
            bus.A_load      = 1'b1;
            bus.B_load      = 1'b1;
            bus.ALUSrcB     = 2'b11;
            bus.ALUOut_load = 1'b1;
            case (bus.Opcode)
               6'h00:        state_n = S_REXEC;
               6'h23, 6'h2B: state_n = S_MEMADR;
               6'h04, 6'h05: state_n = S_BRANCH;
               6'h02:        state_n = S_JUMP;
               6'h08:        state_n = S_IEXEC;
               default:      state_n = S_EXC;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = 2'b10;
            bus.ALUOut_load = 1'b1;
            state_n = (bus.Opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            bus.IorD = 1'b1;
            if (done) begin
               bus.MDR_load = 1'b1;
               cnt_n        = 4'd0;
               state_n      = S_MEMWB;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         S_MEMWB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
            state_n      = S_FETCH;
         end
         S_MEMWR: begin
            bus.IorD = 1'b1;
            bus.wr   = 1'b1;
            state_n  = S_FETCH;
         end
         S_REXEC: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = 2'b10;
            bus.ALUOut_load = 1'b1;
            ovf_n   = arith_trap & bus.Overflow;
            state_n = S_RWB;
         end
         S_IEXEC: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = 2'b10;
            bus.ALUOut_load = 1'b1;
            ovf_n   = bus.Overflow;
            state_n = S_IWB;
         end
         S_RWB, S_IWB: begin
            if (ovf) begin
               state_n = S_EXC;
            end else begin
               bus.RegWrite = 1'b1;
               bus.RegDst   = (state == S_RWB);
               state_n      = S_FETCH;
            end
         end
         S_BRANCH: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = 2'b01;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
            bus.BranchNE    = (bus.Opcode == 6'h05);
            state_n         = S_FETCH;
         end
         S_JUMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
            state_n      = S_FETCH;
         end
         S_EXC: begin
            bus.ALUSrcB  = 2'b01;
            bus.ALUOp    = 2'b01;
            bus.EPCWrite = 1'b1;
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b11;
            ovf_n        = 1'b0;
            state_n      = S_FETCH;
         end
         default: state_n = S_RESET;
      endcase
   end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control (MEM_WAIT=1): per-cycle state and
// control checks for every instruction class plus async reset mid-load.
module tb_mips_multicycle_control;
   logic Clk;
   logic reset;

   mips_multicycle_control_if bus ();

   mips_multicycle_control #(.MEM_WAIT(1)) dut (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       PCWrite;
      logic       PCWriteCond;
      logic       BranchNE;
      logic       IorD;
      logic       wr;
      logic       MemtoReg;
      logic       IRWrite;
      logic       RegWrite;
      logic       RegDst;
      logic       RegReset;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [1:0] ALUOp;
      logic [1:0] PCSource;
      logic       A_load;
      logic       B_load;
      logic       ALUOut_load;
      logic       MDR_load;
      logic       EPCWrite;
   } ctl_t;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        ovf;
      logic [31:0] seq;
      int          len;
   } vec_t;

   typedef struct {
      int         vec;
      int         cyc;
      logic [7:0] st;
      ctl_t       ctl;
   } exp_t;

   vec_t vecs [13];
   exp_t sb [$];
   int   checks;
   int   errors;

   function automatic ctl_t actual_ctl();
      ctl_t c;
      c.PCWrite     = bus.PCWrite;
      c.PCWriteCond = bus.PCWriteCond;
      c.BranchNE    = bus.BranchNE;
      c.IorD        = bus.IorD;
      c.wr          = bus.wr;
      c.MemtoReg    = bus.MemtoReg;
      c.IRWrite     = bus.IRWrite;
      c.RegWrite    = bus.RegWrite;
      c.RegDst      = bus.RegDst;
      c.RegReset    = bus.RegReset;
      c.ALUSrcA     = bus.ALUSrcA;
      c.ALUSrcB     = bus.ALUSrcB;
      c.ALUOp       = bus.ALUOp;
      c.PCSource    = bus.PCSource;
      c.A_load      = bus.A_load;
      c.B_load      = bus.B_load;
      c.ALUOut_load = bus.ALUOut_load;
      c.MDR_load    = bus.MDR_load;
      c.EPCWrite    = bus.EPCWrite;
      return c;
   endfunction

   // Expected controls for one cycle, straight from the state descriptions.
   function automatic ctl_t exp_ctl(input logic [3:0] st, input logic fin,
                                    input logic [5:0] op, input logic trap);
      ctl_t c;
      c = '0;
      case (st)
         4'd0: c.RegReset = 1'b1;
         4'd1: begin
            c.ALUSrcB = 2'b01;
            c.IRWrite = fin;
            c.PCWrite = fin;
         end
         4'd2: begin
            c.A_load = 1'b1; c.B_load = 1'b1;
            c.ALUSrcB = 2'b11; c.ALUOut_load = 1'b1;
         end
         4'd3: begin
            c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; c.ALUOut_load = 1'b1;
         end
         4'd4: begin
            c.IorD = 1'b1; c.MDR_load = fin;
         end
         4'd5: begin
            c.MemtoReg = 1'b1; c.RegWrite = 1'b1;
         end
         4'd6: begin
            c.IorD = 1'b1; c.wr = 1'b1;
         end
         4'd7: begin
            c.ALUSrcA = 1'b1; c.ALUOp = 2'b10; c.ALUOut_load = 1'b1;
         end
         4'd8: begin
            c.RegWrite = ~trap; c.RegDst = ~trap;
         end
         4'd9: begin
            c.ALUSrcA = 1'b1; c.ALUOp = 2'b01; c.PCWriteCond = 1'b1;
            c.PCSource = 2'b01; c.BranchNE = (op == 6'h05);
         end
         4'd10: begin
            c.PCWrite = 1'b1; c.PCSource = 2'b10;
         end
         4'd11: begin
            c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; c.ALUOut_load = 1'b1;
         end
         4'd12: c.RegWrite = ~trap;
         4'd13: begin
            c.ALUSrcB = 2'b01; c.ALUOp = 2'b01; c.EPCWrite = 1'b1;
            c.PCWrite = 1'b1; c.PCSource = 2'b11;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] seq_at(input vec_t v, input int i);
      return v.seq[4*(v.len-1-i) +: 4];
   endfunction

   task automatic push_vec(input int k);
      vec_t v;
      exp_t e;
      logic [3:0] s, nx;
      v = vecs[k];
      for (int i = 0; i < v.len; i++) begin
         s  = seq_at(v, i);
         nx = (i == v.len - 1) ? 4'd1 : seq_at(v, i + 1);
         e.vec = k;
         e.cyc = i;
         e.st  = {4'b0000, s};
         e.ctl = exp_ctl(s, nx != s, v.op, nx == 4'd13);
         sb.push_back(e);
      end
   endtask

   task automatic check_cycle();
      exp_t e;
      ctl_t a;
      e = sb.pop_front();
      a = actual_ctl();
      checks++;
      if (bus.Estado !== e.st || a !== e.ctl) begin
         errors++;
         $display("FAIL vec%0d cyc%0d: Estado=%0d ctl=%h, want Estado=%0d ctl=%h",
                  e.vec, e.cyc, bus.Estado, a, e.st, e.ctl);
      end
   endtask

   task automatic check_val(input string nm, input logic [31:0] act,
                            input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, act, want);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.Opcode   = v.op;
      bus.Funct    = v.fn;
      bus.Overflow = v.ovf;
   endtask

   initial begin
      //               op     fn     ovf   states (hex, in order)  len
      vecs[0]  = '{6'h23, 6'h00, 1'b0, 32'h1123445,  7};
      vecs[1]  = '{6'h2B, 6'h00, 1'b0, 32'h11236,    5};
      vecs[2]  = '{6'h00, 6'h20, 1'b0, 32'h11278,    5};
      vecs[3]  = '{6'h00, 6'h20, 1'b1, 32'h11278D,   6};
      vecs[4]  = '{6'h00, 6'h21, 1'b1, 32'h11278,    5};
      vecs[5]  = '{6'h00, 6'h22, 1'b1, 32'h11278D,   6};
      vecs[6]  = '{6'h00, 6'h24, 1'b1, 32'h11278,    5};
      vecs[7]  = '{6'h08, 6'h00, 1'b0, 32'h112BC,    5};
      vecs[8]  = '{6'h08, 6'h00, 1'b1, 32'h112BCD,   6};
      vecs[9]  = '{6'h04, 6'h00, 1'b0, 32'h1129,     4};
      vecs[10] = '{6'h05, 6'h00, 1'b0, 32'h1129,     4};
      vecs[11] = '{6'h02, 6'h00, 1'b0, 32'h112A,     4};
      vecs[12] = '{6'h3F, 6'h00, 1'b0, 32'h112D,     4};

      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.Opcode = 6'h00; bus.Funct = 6'h00;
      bus.Zero = 1'b0; bus.Overflow = 1'b0;
      repeat (2) @(negedge Clk);
      check_val("reset_estado", 32'(bus.Estado), 32'd0);
      check_val("reset_ctl", 32'(actual_ctl()), 32'(exp_ctl(4'd0, 1'b1, 6'h00, 1'b0)));

      reset = 1'b0;
      #1 check_val("release_estado", 32'(bus.Estado), 32'd0);
      apply(vecs[0]);
      for (int k = 0; k < 13; k++) begin
         push_vec(k);
         for (int i = 0; i < vecs[k].len; i++) begin
            @(negedge Clk);
            bus.Zero = 1'($urandom_range(0, 1));
            check_cycle();
         end
         if (k < 12) apply(vecs[k + 1]);
      end

      // Async reset in the middle of a load's memory wait.
      apply(vecs[0]);
      repeat (5) @(negedge Clk);
      check_val("pre_reset_memrd", 32'(bus.Estado), 32'd4);
      #2 reset = 1'b1;
      #1;
      check_val("async_estado", 32'(bus.Estado), 32'd0);
      check_val("async_strobes",
                {29'd0, bus.RegWrite, bus.wr, bus.PCWrite}, 32'd0);
      check_val("async_regreset", 32'(bus.RegReset), 32'd1);
      @(negedge Clk);
      reset = 1'b0;
      #1 check_val("post_release_reset", 32'(bus.Estado), 32'd0);
      @(negedge Clk);
      check_val("post_release_fetch", 32'(bus.Estado), 32'd1);
      check_val("queue_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
